dct_quant_zigzag: RTL and testbench

//  Stage directly downstream of dct_2d: accepts its coefficient stream, one per clock, in column-major order.

---
 rtl/dct_quant_zigzag_pkg.sv | 54 +++++
 rtl/dct_quant_zigzag_if.sv | 28 ++
 rtl/dct_quant_zigzag_quant_mul.sv | 60 ++++++
 rtl/dct_quant_zigzag.sv | 135 +++++++++++++
 tb/tb_dct_quant_zigzag.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_quant_zigzag_pkg.sv
// Types and constant tables for the quantise/zigzag stage. Every table is indexed in
// input order k = u*8 + v (column-major, as produced by dct_2d).
package dct_quant_zigzag_pkg;

   localparam int CW = 15;             // coefficient width, signed
   localparam int RW = 17;             // reciprocal width, unsigned
   localparam int PW = CW + RW + 1;    // product width incl. zero-extended reciprocal sign

   typedef logic signed [CW-1:0] coef_t;
   typedef logic        [RW-1:0] recip_t;
   typedef logic        [5:0]    idx_t;

   typedef enum logic {
      RD_IDLE,
      RD_DRAIN
   } rd_state_e;

   // zigzag position j -> input index k
   localparam idx_t ZIGZAG [64] = '{
       0,  8,  1,  2,  9, 16, 24, 17,
      10,  3,  4, 11, 18, 25, 32, 40,
      33, 26, 19, 12,  5,  6, 13, 20,
      27, 34, 41, 48, 56, 49, 42, 35,
      28, 21, 14,  7, 15, 22, 29, 36,
      43, 50, 57, 58, 51, 44, 37, 30,
      23, 31, 38, 45, 52, 59, 60, 53,
      46, 39, 47, 54, 61, 62, 55, 63
   };

   // JPEG luminance quantiser, quality 50, one column (fixed u) per row
   localparam logic [7:0] QUANT_DEFAULT [64] = '{
       16,  12,  14,  14,  18,  24,  49,  72,
       11,  12,  13,  17,  22,  35,  64,  92,
       10,  14,  16,  22,  37,  55,  78,  95,
       16,  19,  24,  29,  56,  64,  87,  98,
       24,  26,  40,  51,  68,  81, 103, 112,
       40,  58,  57,  87, 109, 104, 121, 100,
       51,  60,  69,  80, 103, 113, 120, 103,
       61,  55,  56,  62,  77,  92, 101,  99
   };

   // round(2^16 / QUANT_DEFAULT[k])
   localparam recip_t QRECIP_DEFAULT [64] = '{
      4096, 5461, 4681, 4681, 3641, 2731, 1337,  910,
      5958, 5461, 5041, 3855, 2979, 1872, 1024,  712,
      6554, 4681, 4096, 2979, 1771, 1192,  840,  690,
      4096, 3449, 2731, 2260, 1170, 1024,  753,  669,
      2731, 2521, 1638, 1285,  964,  809,  636,  585,
      1638, 1130, 1150,  753,  601,  630,  542,  655,
      1285, 1092,  950,  819,  636,  580,  546,  636,
      1074, 1192, 1170, 1057,  851,  712,  649,  662
   };

endpackage

// File: rtl/dct_quant_zigzag_if.sv
// Coefficient stream into and out of the quantise/zigzag stage; no backpressure in either direction.
// slave = the stage itself, master = the producer/consumer pair around it.
interface dct_quant_zigzag_if;
   import dct_quant_zigzag_pkg::*;

   logic  ena;
   coef_t in_coef;
   coef_t out_coef;
   logic  out_valid;
   logic  out_sob;

   modport master (
      output ena,
      output in_coef,
      input  out_coef,
      input  out_valid,
      input  out_sob
   );

   modport slave (
      input  ena,
      input  in_coef,
      output out_coef,
      output out_valid,
      output out_sob
   );

endinterface

// File: rtl/dct_quant_zigzag_quant_mul.sv
// Signed coefficient x unsigned reciprocal, then >>16 rounding half away from zero.
// Latency 2 cycles, one sample per clock, no backpressure; valid and index ride alongside.
module dct_quant_zigzag_quant_mul
   import dct_quant_zigzag_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   vld_i,
   input  idx_t   idx_i,
   input  coef_t  coef_i,
   input  recip_t recip_i,
   output logic   vld_o,
   output idx_t   idx_o,
   output coef_t  q_o
);

   localparam logic [PW-1:0] HALF = PW'(1) << 15;

   logic [PW-1:0] prod_d, prod_q;
   logic          vld1_q;
   idx_t          idx1_q;
   logic [PW-1:0] mag, rnd, res;
   coef_t         q_d, q_q;
   logic          vld2_q;
   idx_t          idx2_q;

   // Low PW bits of an unsigned product of the extended operands equal the signed product.
   always_comb begin
      prod_d = {{(PW-CW){coef_i[CW-1]}}, coef_i} * {{(PW-RW){1'b0}}, recip_i};
   end

   always_comb begin
      mag = prod_q[PW-1] ? (~prod_q + PW'(1)) : prod_q;
      rnd = (mag + HALF) >> 16;
      res = prod_q[PW-1] ? (~rnd + PW'(1)) : rnd;
      q_d = CW'(res);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld1_q <= 1'b0;
         vld2_q <= 1'b0;
      end else begin
         vld1_q <= vld_i;
         vld2_q <= vld1_q;
      end
   end

   always_ff @(posedge clk_i) begin
      prod_q <= prod_d;
      idx1_q <= idx_i;
      q_q    <= q_d;
      idx2_q <= idx1_q;
   end

   assign vld_o = vld2_q;
   assign idx_o = idx2_q;
   assign q_o   = q_q;

endmodule

// File: rtl/dct_quant_zigzag.sv
// Quantise dct_2d coefficients and reorder each 8x8 block to zigzag via ping-pong banks; 1 sample/clk,
// first output 3 clks after the 64th input, no backpressure. QTABLE_LOAD_EN adds a writable reciprocal table.
module dct_quant_zigzag
   import dct_quant_zigzag_pkg::*;
(
   input  logic   clk_i,
   input  logic   rst_i,
`ifdef QTABLE_LOAD_EN
   input  logic   qt_we_i,
   input  idx_t   qt_addr_i,
   input  recip_t qt_recip_i,
`endif
   dct_quant_zigzag_if.slave bus
);

   idx_t      k_d, k_q;
   recip_t    recip;
   logic      mul_vld;
   idx_t      mul_idx;
   coef_t     mul_q;
   logic      swap;
   logic      wr_bank_d, wr_bank_q;
   rd_state_e state_d, state_q;
   idx_t      j_d, j_q;
   coef_t     rd_data;
   coef_t     out_d, out_q;
   logic      out_valid_d, out_valid_q;
   logic      out_sob_d, out_sob_q;
   coef_t     ram0 [64];
   coef_t     ram1 [64];

   assign k_d = bus.ena ? k_q + 6'd1 : k_q;

`ifdef QTABLE_LOAD_EN
   recip_t qt_q [64];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 64; i++) begin
            qt_q[i] <= QRECIP_DEFAULT[i];
         end
      end else if (qt_we_i) begin
         qt_q[qt_addr_i] <= qt_recip_i;
      end
   end

   assign recip = qt_q[k_q];
`else
   assign recip = QRECIP_DEFAULT[k_q];
`endif

   dct_quant_zigzag_quant_mul u_quant_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .vld_i   (bus.ena),
      .idx_i   (k_q),
      .coef_i  (bus.in_coef),
      .recip_i (recip),
      .vld_o   (mul_vld),
      .idx_o   (mul_idx),
      .q_o     (mul_q)
   );

   assign swap = mul_vld && (mul_idx == 6'd63);

   // Banks are plain RAMs: reset leaves their contents alone.
   always_ff @(posedge clk_i) begin
      if (mul_vld && !wr_bank_q) begin
         ram0[mul_idx] <= mul_q;
      end
      if (mul_vld && wr_bank_q) begin
         ram1[mul_idx] <= mul_q;
      end
   end

   // The read bank is always the one not being written.
   assign rd_data = wr_bank_q ? ram0[ZIGZAG[j_q]] : ram1[ZIGZAG[j_q]];

   always_comb begin
      state_d     = state_q;
      j_d         = j_q;
      wr_bank_d   = wr_bank_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      out_sob_d   = 1'b0;
      case (state_q)
         RD_IDLE: begin
            state_d = RD_IDLE;
         end
         RD_DRAIN: begin
            out_d       = rd_data;
            out_valid_d = 1'b1;
            out_sob_d   = (j_q == 6'd0);
            j_d         = j_q + 6'd1;
            if (j_q == 6'd63) begin
               state_d = RD_IDLE;
            end
         end
      endcase
      // A swap landing on j=63 restarts the drain with no bubble.
      if (swap) begin
         wr_bank_d = ~wr_bank_q;
         state_d   = RD_DRAIN;
         j_d       = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         k_q         <= '0;
         wr_bank_q   <= 1'b0;
         state_q     <= RD_IDLE;
         j_q         <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_sob_q   <= 1'b0;
      end else begin
         k_q         <= k_d;
         wr_bank_q   <= wr_bank_d;
         state_q     <= state_d;
         j_q         <= j_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_sob_q   <= out_sob_d;
      end
   end

   assign bus.out_coef  = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sob   = out_sob_q;

   a_no_overrun : assert property (@(posedge clk_i) disable iff (rst_i)
      !(swap && (state_q == RD_DRAIN) && (j_q != 6'd63)));

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Bench for dct_quant_zigzag: vector blocks, zigzag order, gaps, reset mid-block, scoreboarded stream.
module tb_dct_quant_zigzag;
   import dct_quant_zigzag_pkg::*;

   typedef struct {
      coef_t val;
      logic  sob;
      int    cyc;
   } exp_t;

   typedef struct {
      coef_t din;
      int    k;
      coef_t exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   dct_quant_zigzag_if bus();
`ifdef QTABLE_LOAD_EN
   logic   qt_we;
   idx_t   qt_addr;
   recip_t qt_recip;
`endif

   dct_quant_zigzag dut (
      .clk_i      (clk),
      .rst_i      (rst),
`ifdef QTABLE_LOAD_EN
      .qt_we_i    (qt_we),
      .qt_addr_i  (qt_addr),
      .qt_recip_i (qt_recip),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int    checks;
   int    errors;
   int    cyc;
   exp_t  exp_q[$];
   int    rtab[64];
   int    zz_ref[64];
   coef_t blk[64];
   coef_t ezz[64];

   task automatic chk(input string name, input int got, input int req);
      checks++;
      if (got != req) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, req);
      end
   endtask

   task automatic mon();
      exp_t e;
      if (bus.out_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out cyc=%0d got val=%0d sob=%0b, required no output",
                     cyc, bus.out_coef, bus.out_sob);
         end else begin
            e = exp_q.pop_front();
            if (bus.out_coef !== e.val || bus.out_sob !== e.sob || cyc != e.cyc) begin
               errors++;
               $display("FAIL stream_out got val=%0d sob=%0b cyc=%0d, required val=%0d sob=%0b cyc=%0d",
                        bus.out_coef, bus.out_sob, cyc, e.val, e.sob, e.cyc);
            end
         end
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge only.
   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      mon();
   endtask

   task automatic drive_block(input bit gapped, input bit push, input int nsamp);
      exp_t e;
      for (int k = 0; k < nsamp; k++) begin
         bus.ena     = 1'b1;
         bus.in_coef = blk[k];
         if (push && k == 63) begin
            for (int j = 0; j < 64; j++) begin
               e.val = ezz[j];
               e.sob = (j == 0);
               e.cyc = cyc + 1 + 3 + j;
               exp_q.push_back(e);
            end
         end
         step();
         if (gapped) begin
            bus.ena     = 1'b0;
            bus.in_coef = coef_t'($urandom);
            step();
         end
      end
   endtask

   task automatic drain();
      bus.ena = 1'b0;
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
         step();
      end
      repeat (4) step();
      chk("drain_outstanding", exp_q.size(), 0);
      exp_q.delete();
   endtask

   function automatic coef_t qmodel(input int x, input int r);
      longint p, a;
      p = longint'(x) * longint'(r);
      a = (p < 0) ? -p : p;
      a = (a + 64'sd32768) >>> 16;
      return coef_t'((p < 0) ? -a : a);
   endfunction

   task automatic model_block();
      for (int j = 0; j < 64; j++) begin
         ezz[j] = qmodel(int'(blk[zz_ref[j]]), rtab[zz_ref[j]]);
      end
   endtask

   task automatic random_block();
      for (int k = 0; k < 64; k++) begin
         blk[k] = coef_t'(int'($urandom_range(8000)) - 4000);
      end
   endtask

`ifdef QTABLE_LOAD_EN
   task automatic load_table(input bit unity);
      for (int i = 0; i < 64; i++) begin
         qt_we    = 1'b1;
         qt_addr  = idx_t'(i);
         qt_recip = unity ? recip_t'(65536) : QRECIP_DEFAULT[i];
         rtab[i]  = int'(qt_recip);
         step();
      end
      qt_we = 1'b0;
   endtask
`endif

   initial begin
      vec_t vecs[10];
      int   n;

      vecs[0] = '{din:    800, k:  0, exp:    50};
      vecs[1] = '{din:    -24, k:  0, exp:    -2};
      vecs[2] = '{din:     24, k:  0, exp:     2};
      vecs[3] = '{din:      8, k:  0, exp:     1};
      vecs[4] = '{din:     -8, k:  0, exp:    -1};
      vecs[5] = '{din:      7, k:  0, exp:     0};
      vecs[6] = '{din:   1000, k:  8, exp:    91};
      vecs[7] = '{din: -16384, k:  2, exp: -1170};
      vecs[8] = '{din:   -100, k: 63, exp:    -1};
      vecs[9] = '{din:     60, k:  5, exp:     3};

      // Reference zigzag walk over anti-diagonals, mapped to column-major k = c*8 + r.
      n = 0;
      for (int s = 0; s < 15; s++) begin
         for (int i = 0; i < 8; i++) begin
            int r, c;
            r = (s % 2 == 1) ? i : 7 - i;
            c = s - r;
            if (c >= 0 && c < 8) begin
               zz_ref[n] = c * 8 + r;
               n++;
            end
         end
      end
      for (int i = 0; i < 64; i++) begin
         rtab[i] = int'(QRECIP_DEFAULT[i]);
      end

      checks      = 0;
      errors      = 0;
      cyc         = 0;
      rst         = 1'b1;
      bus.ena     = 1'b0;
      bus.in_coef = '0;
`ifdef QTABLE_LOAD_EN
      qt_we    = 1'b0;
      qt_addr  = '0;
      qt_recip = '0;
`endif
      repeat (3) step();
      chk("reset_out", int'(bus.out_coef), 0);
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_out_sob", int'(bus.out_sob), 0);
      rst = 1'b0;
      step();

      // Single-coefficient blocks, back to back: rounding, positions, contiguity, latency.
      for (int v = 0; v < 10; v++) begin
         for (int k = 0; k < 64; k++) begin
            blk[k] = (k == vecs[v].k) ? vecs[v].din : coef_t'(0);
         end
         for (int j = 0; j < 64; j++) begin
            ezz[j] = (zz_ref[j] == vecs[v].k) ? vecs[v].exp : coef_t'(0);
         end
         drive_block(1'b0, 1'b1, 64);
      end
      drain();

`ifdef QTABLE_LOAD_EN
      load_table(1'b1);
      for (int k = 0; k < 64; k++) begin
         blk[k] = coef_t'(k);
      end
      for (int j = 0; j < 64; j++) begin
         ezz[j] = coef_t'(zz_ref[j]);
      end
      drive_block(1'b0, 1'b1, 64);
      drain();
      load_table(1'b0);
`endif

      // in = k*Q[k] quantises back to k, so the output stream is the zigzag index sequence.
      for (int k = 0; k < 64; k++) begin
         blk[k] = coef_t'(k * int'(QUANT_DEFAULT[k]));
      end
      for (int j = 0; j < 64; j++) begin
         ezz[j] = coef_t'(zz_ref[j]);
      end
      drive_block(1'b0, 1'b1, 64);
      drain();

      // Same random block ungapped, then with ena toggling every cycle.
      random_block();
      model_block();
      drive_block(1'b0, 1'b1, 64);
      drive_block(1'b1, 1'b1, 64);
      drain();

      // Reset after k=0..30: nothing from the partial block, next block is clean.
      random_block();
      drive_block(1'b0, 1'b0, 31);
      rst     = 1'b1;
      bus.ena = 1'b0;
      step();
      step();
      chk("midrst_out", int'(bus.out_coef), 0);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_out_sob", int'(bus.out_sob), 0);
      rst = 1'b0;
      repeat (5) step();
      random_block();
      model_block();
      drive_block(1'b0, 1'b1, 64);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
